// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - fetch/data requester and SRAM port signal bundle
//
// Groups everything that crosses the arbiter boundary:
//   inst_*  : fetch requester (req/addr in, addr_ok/data_ok/rdata out)
//   data_*  : load/store requester (req/wr/wen/addr/wdata in, addr_ok/data_ok/rdata out)
//   mem_*   : unified SRAM port (en/wen/addr/wdata out, rdata in)
// slave  : seen from the arbiter
// master : seen from the requesters and SRAM model
interface sram_port_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wen, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_en, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wen, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_en, mem_wen, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one fixed-latency SRAM port between fetch and data requesters
//
// Ports:
//   clk_i   : clock, all state on rising edge
//   rst_i   : asynchronous active-high reset
//   bus_io  : sram_port_arbiter_if.slave (requester handshakes + SRAM port)
// Parameters:
//   LAT        : SRAM read latency in cycles (1..4)
//   STARVE_MAX : consecutive fetch denials before fetch overrides data (1..15)
module sram_port_arbiter #(
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  sram_port_arbiter_if.slave bus_io
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic           grant_data;
  logic           grant_inst;
  logic           starve_hit;
  logic [3:0]     starve_cnt_q, starve_cnt_d;
  logic [LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [LAT-1:0] pipe_own_q, pipe_own_d;  // 0 = fetch, 1 = data

  // Data wins unless a waiting fetch has been denied STARVE_MAX times in a row.
  // Grants are forced low while reset is held so the SRAM sees no access.
  always_comb begin
    starve_hit = bus_io.inst_req && (starve_cnt_q == STARVE_LIM);
    grant_data = !rst_i && bus_io.data_req && !starve_hit;
    grant_inst = !rst_i && bus_io.inst_req && !grant_data;
  end

  assign bus_io.data_addr_ok = grant_data;
  assign bus_io.inst_addr_ok = grant_inst;

  assign bus_io.mem_en    = grant_data | grant_inst;
  assign bus_io.mem_addr  = grant_data ? bus_io.data_addr : bus_io.inst_addr;
  assign bus_io.mem_wen   = (grant_data && bus_io.data_wr) ? bus_io.data_wen : 4'b0000;
  assign bus_io.mem_wdata = bus_io.data_wdata;

  // Counts only cycles where fetch waits behind data; the saturation check is
  // defensive since grant_data is never asserted with a waiting fetch at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus_io.inst_req || grant_inst) begin
      starve_cnt_d = 4'd0;
    end else if (grant_data && (starve_cnt_q != STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // Ownership pipeline mirrors the SRAM latency; it never stalls, so responses
  // leave in acceptance order exactly LAT cycles after the grant.
  always_comb begin
    pipe_vld_d    = pipe_vld_q;
    pipe_own_d    = pipe_own_q;
    pipe_vld_d[0] = grant_data | grant_inst;
    pipe_own_d[0] = grant_data;
    for (int i = 1; i < LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_own_d[i] = pipe_own_q[i-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt_q <= 4'd0;
      pipe_vld_q   <= '0;
      pipe_own_q   <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_own_q   <= pipe_own_d;
    end
  end

  assign bus_io.inst_data_ok = pipe_vld_q[LAT-1] && !pipe_own_q[LAT-1];
  assign bus_io.data_data_ok = pipe_vld_q[LAT-1] &&  pipe_own_q[LAT-1];
  assign bus_io.inst_rdata   = bus_io.mem_rdata;
  assign bus_io.data_rdata   = bus_io.mem_rdata;

endmodule
